// File: rtl/ads_pkg.sv
// ads_pkg: shared defaults, state encoding and active-channel clamp for the ADS channel demux
package ads_pkg;
  localparam logic [15:0] START_PKG_DEF = 16'h0006;
  localparam logic [15:0] ALARM_PKG_DEF = 16'h0019;
  localparam int MAX_CH = 8;
  localparam int DATA_W_DEF = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  function automatic logic [3:0] clamp_n(input logic [3:0] req, input int num_ch);
    return (req == 4'd0 || int'(req) > num_ch) ? 4'(num_ch) : req;
  endfunction
endpackage

// File: rtl/ads_cs_edge.sv
// ads_cs_edge: synchronises the async ADC strobe and emits a one-cycle pulse on its rising edge
module ads_cs_edge (
  input  logic clk,
  input  logic rst,
  input  logic ads_cs,
  output logic cs_rise
);
  logic s0_q, r1_q, r2_q, seen_q, arm_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s0_q, r1_q, r2_q, seen_q, arm_q} <= '0;
    end else begin
      s0_q   <= ads_cs;
      r1_q   <= s0_q;
      r2_q   <= r1_q;
      seen_q <= 1'b1;
      // arm only once a genuine post-reset low has been sampled
      arm_q  <= arm_q | (seen_q & ~s0_q);
    end
  end
  assign cs_rise = r1_q & ~r2_q & arm_q;
endmodule

// File: rtl/ads_chan_demux.sv
// ads_chan_demux: steers strobed ADC words into per-channel registers with frame tracking and alarm capture
module ads_chan_demux import ads_pkg::*; #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = DATA_W_DEF,
  parameter logic [15:0] START_PKG = START_PKG_DEF,
  parameter bit          ALARM_EN  = 1'b0,
  parameter logic [15:0] ALARM_PKG = ALARM_PKG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ads_cs,
  input  logic [15:0]              pkg_num,
  input  logic [DATA_W-1:0]        receive_data,
  input  logic [3:0]               ch_count,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               alarm_overview,
  output logic [7:0]               alarm_ch_t,
  output logic [7:0]               alarm_ch_a
);
  logic cs_rise, alarm_hit, run_pkg, cap, last;
  logic [15:0] alarm_off;
  logic [3:0] n_eff;
  logic [7:0] alarm_byte;
  state_t state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] n_q, n_d;
  logic [NUM_CH*DATA_W-1:0] ch_data_q, ch_data_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic done_q, done_d, abort_q, abort_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] ov_q, ov_d, cht_q, cht_d, cha_q, cha_d;

  ads_cs_edge u_edge (.clk(clk), .rst(rst), .ads_cs(ads_cs), .cs_rise(cs_rise));

  assign alarm_off  = pkg_num - ALARM_PKG;
  assign alarm_hit  = ALARM_EN && cs_rise && alarm_off < 16'd3;
  assign alarm_byte = receive_data[DATA_W-1 -: 8];
  assign run_pkg    = pkg_num >= START_PKG;
  assign cap        = cs_rise && !alarm_hit && run_pkg;
  // the edge that enters RUN latches the channel count and uses it immediately
  assign n_eff      = (state_q == ST_IDLE) ? clamp_n(ch_count, NUM_CH) : n_q;
  assign last       = {1'b0, ptr_q} == n_eff - 4'd1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    n_d         = n_q;
    ch_data_d   = ch_data_q;
    ch_valid_d  = '0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    ov_d        = ov_q;
    cht_d       = cht_q;
    cha_d       = cha_q;
    if (alarm_hit) begin
      ov_d  = (alarm_off == 16'd0) ? alarm_byte : ov_q;
      cht_d = (alarm_off == 16'd1) ? alarm_byte : cht_q;
      cha_d = (alarm_off == 16'd2) ? alarm_byte : cha_q;
    end else if (cs_rise && !run_pkg) begin
      abort_d = state_q == ST_RUN && ptr_q != 3'd0;
      ptr_d   = 3'd0;
      state_d = ST_IDLE;
    end else if (cap) begin
      state_d = ST_RUN;
      n_d     = n_eff;
      for (int k = 0; k < NUM_CH; k++) begin
        if (ptr_q == 3'(k)) begin
          ch_data_d[k*DATA_W +: DATA_W] = receive_data;
          ch_valid_d[k] = 1'b1;
        end
      end
      ptr_d       = last ? 3'd0 : ptr_q + 3'd1;
      done_d      = last;
      frame_cnt_d = frame_cnt_q + 16'(last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      n_q         <= 4'(NUM_CH);
      ch_data_q   <= '0;
      ch_valid_q  <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      ov_q        <= 8'd0;
      cht_q       <= 8'd0;
      cha_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      n_q         <= n_d;
      ch_data_q   <= ch_data_d;
      ch_valid_q  <= ch_valid_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
      ov_q        <= ov_d;
      cht_q       <= cht_d;
      cha_q       <= cha_d;
    end
  end

  assign ch_data        = ch_data_q;
  assign ch_valid       = ch_valid_q;
  assign frame_done     = done_q;
  assign frame_abort    = abort_q;
  assign frame_cnt      = frame_cnt_q;
  assign alarm_overview = ov_q;
  assign alarm_ch_t     = cht_q;
  assign alarm_ch_a     = cha_q;
endmodule

// File: tb/tb_ads_chan_demux.sv
// tb_ads_chan_demux: directed and randomized strobes checked against a frame-level reference model
module tb_ads_chan_demux;
  localparam int NCH = 4;
  logic clk = 1'b0, rst = 1'b1, ads_cs = 1'b0;
  logic [15:0] pkg_num = '0, receive_data = '0;
  logic [3:0] ch_count = 4'd4;
  logic [NCH*16-1:0] ch_data;
  logic [NCH-1:0] ch_valid;
  logic frame_done, frame_abort;
  logic [15:0] frame_cnt;
  logic [7:0] alarm_overview, alarm_ch_t, alarm_ch_a;
  int checks = 0, passed = 0, fails = 0;
  logic [15:0] m_ch [NCH];
  logic [7:0] m_al [3];
  logic [15:0] m_cnt;
  int m_pos, m_n;
  bit m_run;
  logic [NCH-1:0] e_valid;
  logic e_done, e_abort;

  always #5 clk = ~clk;

  ads_chan_demux #(.NUM_CH(NCH), .DATA_W(16), .START_PKG(16'h0006), .ALARM_EN(1'b1), .ALARM_PKG(16'h0019)) dut (
    .clk(clk), .rst(rst), .ads_cs(ads_cs), .pkg_num(pkg_num), .receive_data(receive_data),
    .ch_count(ch_count), .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt), .alarm_overview(alarm_overview),
    .alarm_ch_t(alarm_ch_t), .alarm_ch_a(alarm_ch_a));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_ch[k]) m_ch[k] = '0;
    foreach (m_al[k]) m_al[k] = '0;
    m_cnt = '0; m_pos = 0; m_n = NCH; m_run = 0;
    e_valid = '0; e_done = 0; e_abort = 0;
  endtask

  // one received word as the channel/frame rules describe it
  task automatic model_step(input logic [15:0] pkg, input logic [15:0] data, input logic [3:0] chc);
    e_valid = '0; e_done = 0; e_abort = 0;
    if (pkg >= 16'h19 && pkg <= 16'h1B) m_al[int'(pkg - 16'h19)] = data[15:8];
    else if (pkg < 16'd6) begin
      e_abort = m_run && m_pos != 0;
      m_pos = 0; m_run = 0;
    end else begin
      if (!m_run) begin
        m_n = (chc == 0 || int'(chc) > NCH) ? NCH : int'(chc);
        m_run = 1;
      end
      m_ch[m_pos] = data;
      e_valid[m_pos] = 1'b1;
      m_pos++;
      if (m_pos == m_n) begin
        m_pos = 0; e_done = 1; m_cnt++;
      end
    end
  endtask

  function automatic logic [63:0] m_data();
    logic [63:0] v = '0;
    for (int k = 0; k < NCH; k++) v[k*16 +: 16] = m_ch[k];
    return v;
  endfunction

  task automatic check_all();
    chk("ch_valid", 64'(ch_valid), 64'(e_valid));
    chk("frame_done", 64'(frame_done), 64'(e_done));
    chk("frame_abort", 64'(frame_abort), 64'(e_abort));
    chk("ch_data", ch_data, m_data());
    chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    chk("alarm_overview", 64'(alarm_overview), 64'(m_al[0]));
    chk("alarm_ch_t", 64'(alarm_ch_t), 64'(m_al[1]));
    chk("alarm_ch_a", 64'(alarm_ch_a), 64'(m_al[2]));
  endtask

  task automatic do_reset();
    rst = 1'b1; ads_cs = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] pkg, input logic [15:0] data);
    @(negedge clk);
    ads_cs = 1'b1; pkg_num = pkg; receive_data = data;
    @(posedge clk);
    @(posedge clk);
    #1 chk("quiet_before_E2", 64'({ch_valid, frame_done, frame_abort}), 64'd0);
    model_step(pkg, data, ch_count);
    @(posedge clk);
    #1 check_all();
    @(negedge clk) ads_cs = 1'b0;
    @(posedge clk);
    #1 chk("pulse_one_cycle", 64'({ch_valid, frame_done, frame_abort}), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] pk;
    model_reset();
    repeat (4) @(posedge clk);
    #1 check_all();
    do_reset();

    ch_count = 4'd4;
    for (int i = 1; i <= 4; i++) strobe(16'h0006, 16'(i * 16'h1111));
    chk("basic_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("basic_data", ch_data, 64'h4444_3333_2222_1111);

    do_reset();
    ch_count = 4'd2;
    for (int i = 0; i < 5; i++) strobe(16'h0006, 16'(16'hA0 + i));
    chk("n2_frame_cnt", 64'(frame_cnt), 64'd2);
    chk("n2_upper_zero", 64'(ch_data[63:32]), 64'd0);

    do_reset();
    ch_count = 4'd0;
    for (int i = 0; i < 4; i++) strobe(16'h0007, 16'(16'hB0 + i));
    chk("n0_clamp_cnt", 64'(frame_cnt), 64'd1);
    strobe(16'h0005, 16'h0);
    ch_count = 4'd9;
    for (int i = 0; i < 4; i++) strobe(16'h0008, 16'(16'hC0 + i));
    chk("n9_clamp_cnt", 64'(frame_cnt), 64'd2);

    do_reset();
    ch_count = 4'd4;
    strobe(16'h0006, 16'h0D01);
    strobe(16'h0006, 16'h0D02);
    strobe(16'h0005, 16'h0D03);
    chk("abort_cnt", 64'(frame_cnt), 64'd0);
    strobe(16'h0006, 16'h0D04);
    chk("after_abort_ch0", 64'(ch_data[15:0]), 64'h0D04);

    do_reset();
    strobe(16'h0006, 16'h1234);
    strobe(16'h0019, 16'hA500);
    strobe(16'h001A, 16'h5A00);
    strobe(16'h001B, 16'hFF00);
    chk("alarm_bytes", 64'({alarm_overview, alarm_ch_t, alarm_ch_a}), 64'hA55AFF);
    strobe(16'h0006, 16'h5678);
    chk("alarm_ptr_kept", 64'(ch_data[31:0]), 64'h5678_1234);

    do_reset();
    strobe(16'h0006, 16'h0E01);
    strobe(16'h0006, 16'h0E02);
    @(negedge clk);
    ads_cs = 1'b1; pkg_num = 16'h0006; receive_data = 16'hDEAD;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("held_strobe_no_edge", 64'({ch_valid, frame_done, frame_abort}), 64'd0);
    end
    @(negedge clk) ads_cs = 1'b0;
    repeat (3) @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk) release dut.frame_cnt_q;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #1 chk("preset_cnt", 64'(frame_cnt), 64'hFFFF);
    for (int i = 0; i < 4; i++) strobe(16'h0006, 16'(16'hF0 + i));
    chk("cnt_wrap", 64'(frame_cnt), 64'd0);

    for (int i = 0; i < 60; i++) begin
      ch_count = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: pk = 16'($urandom_range(0, 5));
        1, 2, 3, 4: pk = 16'($urandom_range(6, 16'h18));
        5: pk = 16'(16'h19 + $urandom_range(0, 2));
        6: pk = 16'($urandom_range(16'h1C, 16'hFFFF));
        default: pk = 16'h0006;
      endcase
      strobe(pk, 16'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ads_chan_demux.md
ADS_CHAN_DEMUX -- requirements
Module: ads_chan_demux

Interface
REQ-001 Parameter NUM_CH, default 4, number of channel output slots (legal 1..8).
REQ-002 Parameter DATA_W, default 16, width of one ADC sample word.
REQ-003 Parameter START_PKG, default 16'h0006, first pkg_num value at which channel data is valid.
REQ-004 Parameter ALARM_EN, default 0, enables alarm-packet capture.
REQ-005 Parameter ALARM_PKG, default 16'h0019, pkg_num of the first of three alarm packets.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 ads_cs  input  1  asynchronous ADC frame strobe; rising edge marks one received word.
REQ-009 pkg_num  input  16  packet index of current word, stable while ads_cs is high.
REQ-010 receive_data  input  DATA_W  received word, stable from ads_cs rise until capture.
REQ-011 ch_count  input  4  number of active channels, sampled at run start.
REQ-012 ch_data  output  NUM_CH*DATA_W  per-channel latest sample, channel k at bits [k*DATA_W +: DATA_W].
REQ-013 ch_valid  output  NUM_CH  one-cycle pulse on the channel just written.
REQ-014 frame_done  output  1  one-cycle pulse when last active channel written.
REQ-015 frame_abort  output  1  one-cycle pulse when a run ends mid-frame.
REQ-016 frame_cnt  output  16  completed-frame counter.
REQ-017 alarm_overview, alarm_ch_t, alarm_ch_a  output  8 each  latched alarm flag bytes.

Function
REQ-018 ads_cs SHALL pass a 2-flop synchroniser plus one delay flop; rising edge detect = r1 & ~r2.
REQ-019 ads_cs sampled high at edge E0 SHALL produce capture/pulse outputs updated at edge E2 (fixed latency 2 clocks after first high sample).
REQ-020 States: IDLE (pkg_num < START_PKG) and RUN (pkg_num >= START_PKG), evaluated on each detected edge.
REQ-021 IDLE edge: no capture, pointer := 0, no pulses.
REQ-022 IDLE->RUN edge: latch active count N = ch_count, clamped to NUM_CH if 0 or > NUM_CH; this edge captures into channel 0.
REQ-023 RUN edge: ch_data[ptr] := receive_data, ch_valid[ptr] pulses, ptr := ptr+1.
REQ-024 ptr == N-1 on capture: ptr wraps to 0, frame_done pulses same cycle as ch_valid, frame_cnt increments (0xFFFF wraps to 0x0000).
REQ-025 RUN->IDLE edge with ptr != 0: frame_abort pulses, ptr := 0, no capture; ptr == 0: no abort.
REQ-026 ALARM_EN=1 and edge with pkg_num == ALARM_PKG, +1, +2: alarm_overview, alarm_ch_t, alarm_ch_a respectively := receive_data[DATA_W-1 -: 8]; no channel capture, ptr unchanged, state unchanged.
REQ-027 ALARM_EN=0: alarm outputs held at 0; alarm pkg_num values treated as ordinary words.
REQ-028 ch_data and alarm registers SHALL hold between edges; only one ch_valid bit asserted per cycle.
REQ-029 ch_count changes during RUN SHALL have no effect until next IDLE->RUN.

Reset
REQ-030 rst SHALL override all events in the same cycle, including a coincident detected edge.
REQ-031 On rst: synchroniser flops, ptr, state=IDLE, N=NUM_CH, ch_data, ch_valid, frame_done, frame_abort, frame_cnt, all alarm bytes := 0.
REQ-032 rst mid-frame SHALL not pulse frame_abort; a strobe high across rst release SHALL not create an edge until it is seen low then high.

Structure
REQ-033 Shared package ads_pkg: default START_PKG, ALARM_PKG, max channel count 8, DATA_W default, state encoding.
REQ-034 One sub-module ads_cs_edge: synchroniser plus rising-edge pulse, clk/rst/ads_cs in, cs_rise out.

Verification
REQ-035 N=4, pkg_num=6, four strobes with 0x1111..0x4444 -> ch_valid 0001,0010,0100,1000 at E2 each; frame_done with 4th; frame_cnt=1.
REQ-036 ch_count=2, five strobes -> writes ch0,ch1,ch0,ch1,ch0; frame_cnt=2; ch2/ch3 stay 0.
REQ-037 ch_count=0 and ch_count=9 (NUM_CH=4) -> both behave as N=4.
REQ-038 After two captures, strobe with pkg_num=5 -> frame_abort pulse, no ch_valid; next pkg_num=6 strobe writes ch0.
REQ-039 ALARM_EN=1, strobes pkg_num 0x19/0x1A/0x1B data 0xA500/0x5A00/0xFF00 -> alarm bytes 0xA5/0x5A/0xFF, ptr unchanged.
REQ-040 rst asserted same cycle as detected edge, ptr=2 -> all outputs 0, no ch_valid, no frame_abort; frame_cnt preset 0xFFFF then one frame -> 0x0000.
